// File: rtl/i4002.sv
// ============================================================================
//  Module      : i4002
//  Description : MCS-4 data RAM responder. It follows the 8-phase cycle from
//                sync, latches SRC addresses and services the RAM I/O group.
//                Optional status storage is enabled by I4002_STATUS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i4002 #(
  parameter logic [1:0] CHIP_ID = 2'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  input  logic       cm_ram,
  input  logic [3:0] dbus_in,
  output logic [3:0] dbus_out,
  output logic       dbus_oe,
  output logic [3:0] out_port
);

  localparam logic [2:0] c_PH_A1 = 3'd0;
  localparam logic [2:0] c_PH_A2 = 3'd1;
  localparam logic [2:0] c_PH_A3 = 3'd2;
  localparam logic [2:0] c_PH_M1 = 3'd3;
  localparam logic [2:0] c_PH_M2 = 3'd4;
  localparam logic [2:0] c_PH_X1 = 3'd5;
  localparam logic [2:0] c_PH_X2 = 3'd6;
  localparam logic [2:0] c_PH_X3 = 3'd7;

  localparam logic [3:0] c_OP_WRM = 4'h0;
  localparam logic [3:0] c_OP_WMP = 4'h1;
  localparam logic [3:0] c_OP_SBM = 4'h8;
  localparam logic [3:0] c_OP_RDM = 4'h9;
  localparam logic [3:0] c_OP_ADM = 4'hB;

  logic [2:0] r_phase;
  logic [2:0] w_phase_nxt;

  logic       r_src_hi;
  logic       r_src_valid;
  logic [1:0] r_src_chip;
  logic [1:0] r_src_reg;
  logic [3:0] r_src_char;
  logic       r_io_pend;
  logic [3:0] r_opa;
  logic [3:0] r_out_port;

  logic [3:0] r_main [0:63];

  logic       w_selected;
  logic       w_exec;
  logic       w_wr_main;
  logic [5:0] w_main_addr;
  logic [3:0] w_status_rd;

  assign w_selected  = r_src_valid && (r_src_chip == CHIP_ID);
  assign w_exec      = (r_phase == c_PH_X2) && r_io_pend;
  assign w_wr_main   = w_exec && !rst && (r_opa == c_OP_WRM);
  assign w_main_addr = {r_src_reg, r_src_char};
  assign out_port    = r_out_port;

  // Phase tracker: state register
  always_ff @(posedge clk) begin
    if (rst) r_phase <= c_PH_X3;
    else     r_phase <= w_phase_nxt;
  end

  // Phase tracker: next state, parks in X3 until sync arrives
  always_comb begin
    w_phase_nxt = r_phase;
    if (sync)                    w_phase_nxt = c_PH_A1;
    else if (r_phase != c_PH_X3) w_phase_nxt = r_phase + 3'd1;
  end

  // Read drive is combinational so data is valid for the whole X2 phase
  always_comb begin
    dbus_oe  = 1'b0;
    dbus_out = 4'h0;
    if (w_exec) begin
      if (r_opa == c_OP_SBM || r_opa == c_OP_RDM || r_opa == c_OP_ADM) begin
        dbus_oe  = 1'b1;
        dbus_out = r_main[w_main_addr];
      end else if (r_opa[3:2] == 2'b11) begin
        dbus_oe  = 1'b1;
        dbus_out = w_status_rd;
      end
    end
  end

  // SRC address capture: high char in X2, low char in the following X3
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_hi    <= 1'b0;
      r_src_valid <= 1'b0;
      r_src_chip  <= 2'd0;
      r_src_reg   <= 2'd0;
      r_src_char  <= 4'h0;
    end else begin
      r_src_hi <= (r_phase == c_PH_X2) && cm_ram;
      if ((r_phase == c_PH_X2) && cm_ram) begin
        r_src_chip <= dbus_in[3:2];
        r_src_reg  <= dbus_in[1:0];
      end
      if ((r_phase == c_PH_X3) && r_src_hi) begin
        r_src_char  <= dbus_in;
        r_src_valid <= 1'b1;
      end
    end
  end

  // I/O opcode capture; an early sync abandons the pending operation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_io_pend <= 1'b0;
      r_opa     <= 4'h0;
    end else if ((sync && r_phase != c_PH_X3) || r_phase == c_PH_X3) begin
      r_io_pend <= 1'b0;
    end else if ((r_phase == c_PH_M2) && cm_ram && w_selected) begin
      r_io_pend <= 1'b1;
      r_opa     <= dbus_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                              r_out_port <= 4'h0;
    else if (w_exec && r_opa == c_OP_WMP) r_out_port <= dbus_in;
  end

  // Main memory carries no reset; contents are undefined until written
  always_ff @(posedge clk) begin
    if (w_wr_main) r_main[w_main_addr] <= dbus_in;
  end

`ifdef I4002_STATUS_EN
  logic [3:0] r_status [0:15];
  logic       w_wr_status;

  assign w_wr_status = w_exec && !rst && (r_opa[3:2] == 2'b01);
  assign w_status_rd = r_status[{r_src_reg, r_opa[1:0]}];

  always_ff @(posedge clk) begin
    if (w_wr_status) r_status[{r_src_reg, r_opa[1:0]}] <= dbus_in;
  end
`else
  // Without status storage RD0-RD3 still answer, with a zero character
  assign w_status_rd = 4'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i4002.sv
// ============================================================================
//  Module      : tb_i4002
//  Description : Self-checking bench for i4002 driven by instruction-level
//                stimulus and an array-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i4002;

  logic       clk = 1'b0;
  logic       rst;
  logic       sync;
  logic       cm_ram;
  logic [3:0] dbus_in;
  logic [3:0] dbus_out;
  logic       dbus_oe;
  logic [3:0] out_port;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0] m_main [4][16];
  logic [3:0] m_stat [4][4];
  logic [1:0] m_chip;
  logic [1:0] m_reg;
  logic [3:0] m_char;
  bit         m_valid;
  logic [3:0] m_port;

  logic       got_oe;
  logic [3:0] got_out;

  always #5 clk = ~clk;

  i4002 #(.CHIP_ID(2'd0)) dut (
    .clk      (clk),
    .rst      (rst),
    .sync     (sync),
    .cm_ram   (cm_ram),
    .dbus_in  (dbus_in),
    .dbus_out (dbus_out),
    .dbus_oe  (dbus_oe),
    .out_port (out_port)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One phase: drive just after the edge, sample well before the next one
  task automatic tick(input logic s, input logic c, input logic [3:0] d);
    @(posedge clk);
    #1;
    sync    = s;
    cm_ram  = c;
    dbus_in = d;
    #3;
  endtask

  task automatic src_instr(input logic [7:0] addr);
    logic       c;
    logic [3:0] d;
    for (int ph = 0; ph < 8; ph++) begin
      c = (ph == 6) ? 1'b1 : (ph == 4) ? 1'b0 : 1'($urandom_range(0, 1));
      d = (ph == 6) ? addr[7:4] : (ph == 7) ? addr[3:0] : 4'($urandom);
      tick(ph == 7, c, d);
      check("src_oe", {3'b000, dbus_oe}, 4'h0);
    end
    m_valid = 1'b1;
    m_chip  = addr[7:6];
    m_reg   = addr[5:4];
    m_char  = addr[3:0];
    check("src_port", out_port, m_port);
  endtask

  task automatic io_instr(input logic [3:0] opa, input logic [3:0] data,
                          output logic oe_seen, output logic [3:0] out_seen);
    bit         sel;
    logic       exp_oe;
    logic [3:0] exp_out;
    logic       c;
    logic [3:0] d;
    int         op;
    sel     = m_valid && (m_chip == 2'd0);
    exp_oe  = 1'b0;
    exp_out = 4'h0;
    op      = int'(opa);
    if (sel) begin
      if (op == 0) m_main[m_reg][m_char] = data;
      else if (op == 1) m_port = data;
      else if (op >= 4 && op <= 7) begin
`ifdef I4002_STATUS_EN
        m_stat[m_reg][op - 4] = data;
`endif
      end else if (op == 8 || op == 9 || op == 11) begin
        exp_oe  = 1'b1;
        exp_out = m_main[m_reg][m_char];
      end else if (op >= 12) begin
        exp_oe = 1'b1;
`ifdef I4002_STATUS_EN
        exp_out = m_stat[m_reg][op - 12];
`endif
      end
    end
    oe_seen  = 1'b0;
    out_seen = 4'h0;
    for (int ph = 0; ph < 8; ph++) begin
      c = (ph == 4) ? 1'b1 : (ph == 6) ? 1'b0 : 1'($urandom_range(0, 1));
      d = (ph == 4) ? opa : (ph == 6) ? data : 4'($urandom);
      tick(ph == 7, c, d);
      if (ph == 6) begin
        oe_seen  = dbus_oe;
        out_seen = dbus_out;
        check("x2_oe", {3'b000, dbus_oe}, {3'b000, exp_oe});
        check("x2_data", dbus_out, exp_out);
      end else begin
        check("idle_oe", {3'b000, dbus_oe}, 4'h0);
        check("idle_data", dbus_out, 4'h0);
      end
    end
    check("port", out_port, m_port);
  endtask

  initial begin
    rst     = 1'b1;
    sync    = 1'b0;
    cm_ram  = 1'b0;
    dbus_in = 4'h0;
    m_valid = 1'b0;
    m_port  = 4'h0;
    m_chip  = 2'd0;
    m_reg   = 2'd0;
    m_char  = 4'h0;
    tick(1'b0, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 4'h0);
    rst = 1'b0;
    check("reset_oe", {3'b000, dbus_oe}, 4'h0);
    check("reset_data", dbus_out, 4'h0);
    check("reset_port", out_port, 4'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 4'h0);
      check("idle_sync_oe", {3'b000, dbus_oe}, 4'h0);
      check("idle_sync_port", out_port, 4'h0);
    end

    // Define every main and status character before any read
    for (int r = 0; r < 4; r++) begin
      for (int ch = 0; ch < 16; ch++) begin
        src_instr({2'b00, 2'(r), 4'(ch)});
        io_instr(4'h0, 4'($urandom), got_oe, got_out);
      end
      for (int k = 0; k < 4; k++) begin
        src_instr({2'b00, 2'(r), 4'h0});
        io_instr(4'(4 + k), 4'($urandom), got_oe, got_out);
      end
    end

    // WRM then RDM at reg 2 char 5
    src_instr(8'h25);
    io_instr(4'h0, 4'h9, got_oe, got_out);
    io_instr(4'h9, 4'h0, got_oe, got_out);
    check("rdm_oe", {3'b000, got_oe}, 4'h1);
    check("rdm_val", got_out, 4'h9);

    // Another chip selected: no write, no drive
    src_instr(8'h65);
    io_instr(4'h0, 4'h3, got_oe, got_out);
    io_instr(4'h9, 4'h0, got_oe, got_out);
    check("unsel_oe", {3'b000, got_oe}, 4'h0);
    src_instr(8'h25);
    io_instr(4'h9, 4'h0, got_oe, got_out);
    check("unsel_keep", got_out, 4'h9);

    // WMP then WRR
    io_instr(4'h1, 4'hA, got_oe, got_out);
    check("wmp_port", out_port, 4'hA);
    io_instr(4'h2, 4'h5, got_oe, got_out);
    check("wrr_port", out_port, 4'hA);
    check("wrr_oe", {3'b000, got_oe}, 4'h0);

    // WR3 then RD3 on reg 1
    src_instr(8'h10);
    io_instr(4'h7, 4'hC, got_oe, got_out);
    io_instr(4'hF, 4'h0, got_oe, got_out);
    check("rd3_oe", {3'b000, got_oe}, 4'h1);
`ifdef I4002_STATUS_EN
    check("rd3_val", got_out, 4'hC);
`else
    check("rd3_val", got_out, 4'h0);
`endif

    // Reset during X1 of a WRM aborts the write
    src_instr(8'h25);
    for (int ph = 0; ph < 6; ph++) begin
      if (ph == 5) rst = 1'b1;
      tick(1'b0, ph == 4, (ph == 4) ? 4'h0 : 4'h7);
    end
    rst = 1'b0;
    m_valid = 1'b0;
    m_port  = 4'h0;
    tick(1'b1, 1'b0, 4'h7);
    check("rst_mid_port", out_port, 4'h0);
    check("rst_mid_oe", {3'b000, dbus_oe}, 4'h0);
    io_instr(4'h9, 4'h0, got_oe, got_out);
    check("rst_no_src_oe", {3'b000, got_oe}, 4'h0);
    src_instr(8'h25);
    io_instr(4'h9, 4'h0, got_oe, got_out);
    check("rst_keep_val", got_out, 4'h9);

    // Randomized instruction stream against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [1:0] chip;
        chip = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
        src_instr({chip, 2'($urandom), 4'($urandom)});
      end else begin
        io_instr(4'($urandom), 4'($urandom), got_oe, got_out);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
